// File: rtl/alu_defs_pkg.sv
// Shared ALU/command definitions: ALU op codes, sequencer command codes,
// FSM state encoding and the command decode helper.
package alu_defs_pkg;

  localparam logic [2:0] ALU_MOV  = 3'b000;
  localparam logic [2:0] ALU_NOT  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_AND  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_IDLE = 3'b111;

  localparam logic [3:0] CMD_MOV = 4'h0;
  localparam logic [3:0] CMD_NOT = 4'h1;
  localparam logic [3:0] CMD_ADD = 4'h2;
  localparam logic [3:0] CMD_SUB = 4'h3;
  localparam logic [3:0] CMD_OR  = 4'h4;
  localparam logic [3:0] CMD_AND = 4'h5;
  localparam logic [3:0] CMD_SLT = 4'h6;
  localparam logic [3:0] CMD_BEQ = 4'h8;
  localparam logic [3:0] CMD_BNE = 4'h9;
  localparam logic [3:0] CMD_MAX = 4'hA;
  localparam logic [3:0] CMD_MIN = 4'hB;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC1 = 2'd1;
  localparam logic [1:0] ST_EXEC2 = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       two_step;
    logic       is_branch;
    logic       branch_ne;
    logic       pick_max;
    logic       illegal;
  } cmd_dec_t;

  function automatic cmd_dec_t decode_cmd(input logic [3:0] op);
    cmd_dec_t d;
    d = '0;
    d.alu_op = ALU_IDLE;
    case (op)
      CMD_MOV, CMD_NOT, CMD_ADD, CMD_SUB, CMD_OR, CMD_AND, CMD_SLT: d.alu_op = op[2:0];
      CMD_BEQ: begin
        d.alu_op    = ALU_SUB;
        d.is_branch = 1'b1;
      end
      CMD_BNE: begin
        d.alu_op    = ALU_SUB;
        d.is_branch = 1'b1;
        d.branch_ne = 1'b1;
      end
      CMD_MAX: begin
        d.alu_op   = ALU_SLT;
        d.two_step = 1'b1;
        d.pick_max = 1'b1;
      end
      CMD_MIN: begin
        d.alu_op   = ALU_SLT;
        d.two_step = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multicycle command sequencer in front of the combinational 3-bit-opcode ALU:
// accepts a command, steps the ALU once or twice and returns a registered response.
module alu_sequencer
  import alu_defs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_taken,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  logic [1:0]       r_state;
  cmd_dec_t         r_dec;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_slt;
  logic [WIDTH-1:0] r_rspData;
  logic             r_rspZero;
  logic             r_rspTaken;
  logic             r_rspErr;
  logic [CNT_W-1:0] r_count;
  cmd_dec_t         w_cmdDec;
  logic             w_pickB;

  assign w_cmdDec  = decode_cmd(cmd_op);
  assign cmd_ready = (r_state == ST_IDLE) && !rst;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_rspData;
  assign rsp_zero  = r_rspZero;
  assign rsp_taken = r_rspTaken;
  assign rsp_err   = r_rspErr;
  assign op_count  = r_count;

  // MAX keeps b when a<b, MIN keeps b when a>=b.
  assign w_pickB = (r_slt == r_dec.pick_max);

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_IDLE;
    case (r_state)
      ST_EXEC1: begin
        alu_a  = r_a;
        alu_b  = r_b;
        alu_op = r_dec.alu_op;
      end
      ST_EXEC2: begin
        alu_a  = w_pickB ? r_b : r_a;
        alu_op = ALU_MOV;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_dec      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_slt      <= 1'b0;
      r_rspData  <= '0;
      r_rspZero  <= 1'b0;
      r_rspTaken <= 1'b0;
      r_rspErr   <= 1'b0;
      r_count    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_dec <= w_cmdDec;
            r_a   <= cmd_a;
            r_b   <= cmd_b;
            if (w_cmdDec.illegal) begin
              r_rspData  <= '0;
              r_rspZero  <= 1'b0;
              r_rspTaken <= 1'b0;
              r_rspErr   <= 1'b1;
              r_state    <= ST_RESP;
            end else begin
              r_state <= ST_EXEC1;
            end
          end
        end
        ST_EXEC1: begin
          r_rspData  <= alu_out;
          r_rspZero  <= alu_zero;
          r_slt      <= alu_out[0];
          r_rspTaken <= r_dec.is_branch & (alu_zero ^ r_dec.branch_ne);
          r_rspErr   <= r_dec.illegal;
          r_state    <= r_dec.two_step ? ST_EXEC2 : ST_RESP;
        end
        ST_EXEC2: begin
          r_rspData <= alu_out;
          r_state   <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_count <= r_count + CNT_W'(1);
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multicycle ALU sequencer: the command side of the 3-bit-opcode ALU.
- Accepts a command (opcode plus two operands) over a valid/ready handshake.
- Drives the ALU a/b/op_code inputs for one or two steps and captures the ALU out/zero results.
- Returns the result, zero flag, branch decision and error over a second valid/ready handshake.
- Sits between the multicycle control path and the combinational ALU.

Parameters:
WIDTH, 32, datapath width; must match the ALU (32).
CNT_W, 16, width of the completed-command counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  4  command opcode
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
alu_a  output  WIDTH  to ALU a
alu_b  output  WIDTH  to ALU b
alu_op  output  3  to ALU op_code
alu_out  input  WIDTH  from ALU out
alu_zero  input  1  from ALU zero (asserted when a-b==0, independent of op)
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  WIDTH  result
rsp_zero  output  1  captured alu_zero
rsp_taken  output  1  branch decision
rsp_err  output  1  illegal opcode
op_count  output  CNT_W  count of completed responses, wraps

Behaviour:
- ALU op encodings: 000 MOV(a), 001 NOT(~a), 010 ADD, 011 SUB, 100 OR, 101 AND, 110 SLT (unsigned a<b gives 1, else 0), 111 idle (ALU outputs 0).
- Command encodings:
  - 0x0–0x6 map to ALU ops 000–110 directly; single step.
  - 0x8 BEQ: SUB; rsp_taken=alu_zero.
  - 0x9 BNE: SUB; rsp_taken=~alu_zero.
  - 0xA MAX: step1 SLT(a,b); step2 MOV of (slt ? b : a).
  - 0xB MIN: step1 SLT(a,b); step2 MOV of (slt ? a : b).
  - Any other code is illegal.
- FSM states IDLE, EXEC1, EXEC2, RESP.
  - IDLE: cmd_ready=1, alu_op=111. When cmd_valid&cmd_ready, latch op/a/b and go to EXEC1. Illegal op goes directly to RESP with rsp_err=1, rsp_data=0, rsp_zero=0, rsp_taken=0.
  - EXEC1: drive alu_a/alu_b from the latched operands and alu_op from the decoded op. Register alu_out to rsp_data and alu_zero to rsp_zero at the end of the cycle. Next state is EXEC2 for MAX/MIN, else RESP.
  - EXEC2: alu_a = selected operand (from the registered SLT bit), alu_op=000. Register alu_out to rsp_data; rsp_zero keeps its EXEC1 value. Next state is RESP.
  - RESP: rsp_valid=1. Hold rsp_* stable until rsp_ready. On handshake, op_count+1 and go to IDLE.
- cmd_ready is 0 in every state except IDLE; there is no same-cycle overlap of response and new command.
- Latency from the accepting edge to rsp_valid high: single-step 2 edges, two-step 3 edges, illegal 1 edge.
- rsp_taken is 0 for all non-branch ops. rsp_err is 0 for all legal ops.
- Outside EXEC1/EXEC2: alu_a=alu_b=0, alu_op=111.
- rsp_data, rsp_zero, rsp_taken and rsp_err are registered.
- ADD/SUB wrap modulo 2^WIDTH; there is no carry or overflow output.
- op_count wraps from 2^CNT_W−1 to 0.
- Reset, including mid-operation:
  - state returns to IDLE; any in-flight command or pending response is discarded, not counted.
  - cmd_ready=0 while rst is high.
  - rsp_valid=0; rsp_data=0; rsp_zero=rsp_taken=rsp_err=0.
  - op_count=0; alu_a=alu_b=0; alu_op=111.
- cmd_* is ignored outside IDLE. An rsp_ready asserted outside RESP has no effect.

Decomposition:
- Shared package alu_defs_pkg holds:
  - ALU op constants (ALU_MOV … ALU_SLT, ALU_IDLE=3'b111)
  - command opcode constants (CMD_*)
  - FSM state encoding
- The ALU op constants are also used by the ALU itself.
- No sub-module needed. The opcode decode (cmd_op → alu_op, two_step, is_branch, illegal) is a function in the package.

Test Plan:
1. ADD: cmd_op=0x2, a=5, b=7, rsp_ready=1 → rsp_valid 2 edges after acceptance; rsp_data=12, rsp_zero=0, rsp_err=0; op_count=1.
2. BEQ/BNE: 0x8 with a=b=0x1234 → rsp_data=0, rsp_zero=1, rsp_taken=1. Then 0x9 with a=3, b=4 → rsp_data=0xFFFFFFFF, rsp_taken=1.
3. MAX/MIN: 0xA with a=3, b=9 → rsp_data=9 after 3 edges, and alu_op sequence 110 then 000 is observed on the ALU port. 0xB with the same operands → rsp_data=3.
4. Backpressure/illegal: 0x7 with rsp_ready=0 for 5 cycles → rsp_valid=1 and rsp_err=1 held stable, cmd_ready=0 throughout; rsp_ready=1 → next cycle IDLE, op_count increments.
5. Reset mid-op: issue MAX, assert rst during EXEC2 → next edge rsp_valid=0, cmd_ready=1 after rst drops, op_count unchanged (0).
6. Wrap: ADD 0xFFFFFFFF+1 → rsp_data=0, rsp_zero=0. With CNT_W=2, four completions → op_count=0.
